// File: rtl/adc_avg_monitor_if.sv
// adc_avg_monitor_if: sample-in / average-out signal bundle for adc_avg_monitor
interface adc_avg_monitor_if;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       flush;
  logic [7:0] avg_data;
  logic       avg_valid;
  logic       alarm;
  logic       filled;
  modport master (output adc_data, adc_valid, flush, input avg_data, avg_valid, alarm, filled);
  modport slave (input adc_data, adc_valid, flush, output avg_data, avg_valid, alarm, filled);
endinterface

// File: rtl/adc_avg_monitor.sv
// adc_avg_monitor: sliding-window moving average of 8-bit ADC samples with hysteretic alarm
module adc_avg_monitor #(
  parameter int         LOG2_DEPTH = 3,
  parameter logic [7:0] HI_THRESH  = 8'd200,
  parameter logic [7:0] LO_THRESH  = 8'd50
) (
  input logic              sclk,
  input logic              rstn,
  adc_avg_monitor_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW = 8 + LOG2_DEPTH;
  typedef enum logic {FILL, RUN} state_t;
  state_t                r_state, w_state_nxt;
  logic [7:0]            r_buf [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_DEPTH:0]   r_cnt;
  logic [SW-1:0]         r_sum, w_sum_nxt;
  logic [7:0]            w_old, w_avg, r_avg_data;
  logic                  w_acc, w_pub, w_alarm_nxt, r_pend, r_avg_valid, r_alarm;
  always_comb begin
    w_acc       = bus.adc_valid & ~bus.flush;
    w_old       = (r_state == RUN) ? r_buf[r_wr_ptr] : 8'd0;
    w_sum_nxt   = r_sum + SW'(bus.adc_data) - SW'(w_old);
    w_state_nxt = bus.flush ? FILL
                : (w_acc && r_state == FILL && r_cnt == (LOG2_DEPTH+1)'(DEPTH - 1)) ? RUN
                : r_state;
    w_pub       = w_acc && w_state_nxt == RUN;
    w_avg       = r_sum[SW-1:LOG2_DEPTH];
    w_alarm_nxt = (w_avg >= HI_THRESH) ? 1'b1 : (w_avg <= LO_THRESH) ? 1'b0 : r_alarm;
  end
  // window storage is deliberately unreset; FILL masks stale entries out of the sum
  always_ff @(posedge sclk)
    if (w_acc) r_buf[r_wr_ptr] <= bus.adc_data;
  always_ff @(posedge sclk or negedge rstn)
    if (!rstn) begin
      r_state     <= FILL;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_pend      <= 1'b0;
      r_avg_valid <= 1'b0;
      r_avg_data  <= '0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pub;
      r_avg_valid <= r_pend & ~bus.flush;
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_cnt    <= '0;
        r_sum    <= '0;
        r_alarm  <= 1'b0;
      end else begin
        if (w_acc) begin
          r_wr_ptr <= r_wr_ptr + LOG2_DEPTH'(1);
          r_sum    <= w_sum_nxt;
          if (r_state == FILL) r_cnt <= r_cnt + (LOG2_DEPTH+1)'(1);
        end
        if (r_pend) begin
          r_avg_data <= w_avg;
          r_alarm    <= w_alarm_nxt;
        end
      end
    end
  assign bus.avg_data  = r_avg_data;
  assign bus.avg_valid = r_avg_valid;
  assign bus.alarm     = r_alarm;
  assign bus.filled    = r_state == RUN;
endmodule

// File: doc/adc_avg_monitor.md
# adc_avg_monitor

Downstream consumer of the AD7478 ADC driver's 8-bit sample output. Keeps a sliding-window moving average over the last 2^LOG2_DEPTH samples and publishes each average with a one-cycle valid strobe. Also drives a hysteretic over-level alarm from that average. It runs in the system clock domain; the integration wrapper synchronises the driver's sample-update event into the single-cycle `adc_valid` this block consumes.

## Interface
- `LOG2_DEPTH`, 3 — log2 of the window length; the window holds 2^LOG2_DEPTH samples (8 by default); legal range is 1–6.
- `HI_THRESH`, 8'd200 — the alarm sets when the average is ≥ this value.
- `LO_THRESH`, 8'd50 — the alarm clears when the average is ≤ this value; must be < `HI_THRESH`.

- `sclk`  in  1  system clock; all logic is on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `adc_data`  in  8  sample from the ADC stage (`bus08_t`).
- `adc_valid`  in  1  single-cycle strobe; `adc_data` is valid in this cycle.
- `flush`  in  1  synchronous clear of the window, sum and alarm.
- `avg_data`  out  8  latest moving average (`bus08_t`).
- `avg_valid`  out  1  one-cycle strobe: `avg_data` was just updated.
- `alarm`  out  1  level output, hysteretic over-level flag.
- `filled`  out  1  high once the window holds 2^LOG2_DEPTH samples.

## Operation
- Storage:
  - Circular buffer `buf` of 2^LOG2_DEPTH × 8 bits, with write pointer `wr_ptr` (LOG2_DEPTH bits).
  - Fill counter `cnt` (LOG2_DEPTH+1 bits).
  - Running sum `sum` (8+LOG2_DEPTH bits, unsigned). `sum` never overflows by construction.
- The buffer contents are not reset. The oldest-sample operand is forced to 0 while in FILL, so stale contents never reach `sum`.
- State machine, two states:
  - FILL (reset state): on `adc_valid`:
    - `buf[wr_ptr] <= adc_data`
    - `sum <= sum + adc_data`
    - `wr_ptr++`, `cnt++`
    - On the sample that brings `cnt` to 2^LOG2_DEPTH, transition to RUN.
  - RUN: on `adc_valid`:
    - `sum <= sum + adc_data − buf[wr_ptr]`, where `buf[wr_ptr]` is the oldest sample, read before it is overwritten.
    - `buf[wr_ptr] <= adc_data`, `wr_ptr++` (wraps modulo 2^LOG2_DEPTH).
    - `cnt` holds.
- Average and alarm:
  - The average is `sum >> LOG2_DEPTH` (truncating, unsigned); the result fits in 8 bits.
  - It is published only from RUN, including the sample that completes FILL.
  - Alarm update happens on each published average: set if avg ≥ `HI_THRESH`, clear if avg ≤ `LO_THRESH`, otherwise hold.
- `filled` = (state == RUN).
- `flush` behaviour:
  - On `flush` high at an edge: state → FILL; `sum`, `cnt`, `wr_ptr` → 0; `alarm` → 0; `avg_valid` → 0.
  - `avg_data` holds its last value.
  - A pending stage-2 publish is cancelled.
- Simultaneous `flush` and `adc_valid`: flush wins and the sample is dropped.
- Reset mid-operation: identical to flush, and additionally `avg_data` → 0.
- `adc_valid` may assert on every cycle; there is no backpressure and no sample is ever lost except under flush or reset.

## Timing
- Reset values: `avg_data`=0, `avg_valid`=0, `alarm`=0, `filled`=0; internal state=FILL, `sum`=0, `cnt`=0, `wr_ptr`=0.
- Pipeline. Let E be the edge that samples `adc_valid`=1:
  - Stage 1 at E: `buf`, `sum`, `wr_ptr`, `cnt` and state update.
  - Stage 2 at E+1: `avg_data <= sum >> LOG2_DEPTH`, `avg_valid <= 1` when in RUN, and the alarm update.
  - Latency from `adc_valid` to `avg_valid` is 2 rising edges.
- `avg_valid` is high for exactly one cycle per accepted RUN-state sample. With back-to-back `adc_valid`, `avg_valid` is high continuously and a new average appears every cycle.
- `filled` rises at E of the 2^LOG2_DEPTH-th sample, one cycle before the first `avg_valid`.
- `alarm` changes only in the same cycle that `avg_valid` is high (or on flush/reset).

## Test plan
- **Reset:** assert `rstn`=0 asynchronously mid-cycle → all outputs read 0 immediately; after release with no `adc_valid` for 100 cycles, outputs stay 0.
- **Fill:** 8 samples of 100, spaced 4 cycles apart →
  - no `avg_valid` for samples 1–7;
  - `filled` goes high at the edge sampling sample 8;
  - `avg_valid` pulses one cycle later with `avg_data`=100 and `alarm`=0.
- **Step up (continuing):** feed 255s →
  - averages 119, 138, 158, 177, 196, 216, 235, 255;
  - `alarm` sets with 216 (6th sample) and stays set.
- **Hysteresis (continuing):** feed 0s →
  - averages 223, 191, 159, 127, 95, 63, 31, 0;
  - `alarm` stays 1 through 63 and clears with 31.
- **Back-to-back with flush:** `adc_valid` held for 20 cycles with ramp data 0..19 →
  - `avg_valid` continuous from the 10th cycle; the first average is 3 (sum of 0..7 = 28, >>3);
  - assert `flush` together with `adc_valid` at sample 15 → sample 15 dropped, `filled`=0, `alarm`=0, `avg_data` holds, and the next 8 samples refill from empty.
- **Reset mid-RUN:** pulse `rstn` low during a burst → `avg_valid` never glitches high; `avg_data`=0; a subsequent fill of 8×40 yields `avg_data`=40.
